// File: rtl/sequenciador_pilha_ula.sv
// -----------------------------------------------------------------------------
// sequenciador_pilha_ula
//
// Micro-sequencer for the stack (pilha) / temp1 / temp2 / ULA datapath.
// It accepts one stack-machine instruction per start handshake while idle and
// emits one cycle of control per state. The stack depth is tracked here, and
// any instruction that would underflow or overflow the stack is rejected.
//
// Instructions:
//   PUSH imm         : push the captured immediate.
//   POP              : pop and discard the top word.
//   ADD/SUB/AND/OR   : temp1 <= pop (top), temp2 <= pop (next),
//                      push ULA(temp1, temp2).
//   NOP              : complete immediately.
//   111              : illegal, always rejected.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   start_i           instruction request, sampled only while idle
//   opcode_i [2:0]    000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 OR,
//                     110 NOP, 111 illegal
//   imm_data_i        immediate for PUSH, captured with the opcode
//   controle_pilha_o  stack command: 00 hold, 01 push, 10 pop
//   sel_din_o         stack input select: 0 = din_uc_o, 1 = ULA result
//   din_uc_o          captured immediate, stable for the whole instruction
//   load_temp1_o      temp1 captures stack dout at next edge
//   load_temp2_o      temp2 captures stack dout at next edge
//   ula_op_o          00 ADD, 01 SUB (temp1 - temp2), 10 AND, 11 OR
//   busy_o            high in every state except idle
//   done_o            one-cycle pulse: instruction completed
//   erro_o            one-cycle pulse: instruction rejected
//   depth_o           current number of words on the stack
// -----------------------------------------------------------------------------
module sequenciador_pilha_ula #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        opcode_i,
    input  logic [DATA_W-1:0] imm_data_i,
    output logic [1:0]        controle_pilha_o,
    output logic              sel_din_o,
    output logic [DATA_W-1:0] din_uc_o,
    output logic              load_temp1_o,
    output logic              load_temp2_o,
    output logic [1:0]        ula_op_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              erro_o,
    output logic [CNT_W-1:0]  depth_o
);

    // Sequencer states
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PUSH  = 4'd1;
    localparam logic [3:0] S_POP   = 4'd2;
    localparam logic [3:0] S_POP_A = 4'd3;
    localparam logic [3:0] S_POP_B = 4'd4;
    localparam logic [3:0] S_EXEC  = 4'd5;
    localparam logic [3:0] S_WB    = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    // Opcodes
    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;

    // Stack commands
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;

    localparam logic [CNT_W-1:0] DEPTH_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);

    logic [3:0]        state_q, state_d;
    logic [2:0]        op_q,    op_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [CNT_W-1:0]  depth_q, depth_d;

    // -------------------------------------------------------------------------
    // Next-state and depth bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        op_d    = op_q;
        imm_d   = imm_q;
        depth_d = depth_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d  = opcode_i;
                    imm_d = imm_data_i;
                    case (opcode_i)
                        OP_PUSH: state_d = (depth_q == DEPTH_FULL) ? S_ERR : S_PUSH;
                        OP_POP:  state_d = (depth_q == '0)         ? S_ERR : S_POP;
                        OP_ADD, OP_SUB, OP_AND, OP_OR:
                                 state_d = (depth_q < TWO)         ? S_ERR : S_POP_A;
                        OP_NOP:  state_d = S_DONE;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_PUSH: begin
                depth_d = depth_q + ONE;
                state_d = S_DONE;
            end
            S_POP: begin
                depth_d = depth_q - ONE;
                state_d = S_DONE;
            end
            S_POP_A: begin
                depth_d = depth_q - ONE;
                state_d = S_POP_B;
            end
            S_POP_B: begin
                depth_d = depth_q - ONE;
                state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_WB;
            S_WB: begin
                depth_d = depth_q + ONE;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            imm_q   <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            depth_q <= depth_d;
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs: decoded only from registered state, so an asynchronous
    // reset drives every command output to 0 immediately.
    // -------------------------------------------------------------------------
    logic [1:0] ula_code;

    always_comb begin
        // Opcodes 010..101 map onto ULA codes 00..11 in order.
        case (op_q)
            OP_ADD:  ula_code = 2'b00;
            OP_SUB:  ula_code = 2'b01;
            OP_AND:  ula_code = 2'b10;
            OP_OR:   ula_code = 2'b11;
            default: ula_code = 2'b00;
        endcase
    end

    always_comb begin
        controle_pilha_o = CMD_HOLD;
        sel_din_o        = 1'b0;
        load_temp1_o     = 1'b0;
        load_temp2_o     = 1'b0;
        ula_op_o         = 2'b00;
        done_o           = 1'b0;
        erro_o           = 1'b0;
        busy_o           = (state_q != S_IDLE);

        case (state_q)
            S_PUSH:  controle_pilha_o = CMD_PUSH;
            S_POP:   controle_pilha_o = CMD_POP;
            S_POP_A: begin
                controle_pilha_o = CMD_POP;
                load_temp1_o     = 1'b1;
            end
            S_POP_B: begin
                controle_pilha_o = CMD_POP;
                load_temp2_o     = 1'b1;
            end
            S_EXEC:  ula_op_o = ula_code;
            S_WB: begin
                controle_pilha_o = CMD_PUSH;
                sel_din_o        = 1'b1;
                ula_op_o         = ula_code;
            end
            S_DONE:  done_o = 1'b1;
            S_ERR:   erro_o = 1'b1;
            default: ;
        endcase
    end

    assign din_uc_o = imm_q;
    assign depth_o  = depth_q;

endmodule
